writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Single owner of the register file write port (WE3/A3/WD3). Merges the 1-cycle ALU
//  result stream with the long-latency (load/multiply) result stream. Slow results are
//  buffered in a small FIFO and issued in free port slots. An 8-bit busy scoreboard
//  reports registers with an outstanding long-latency write so decode can stall on RAW hazards.
// PARAMETERS
//  DW     16  data width, equal to the register file width
//  AW     3   register address width (2**AW registers; r0 hard-wired zero)
//  DEPTH  2   slow-result FIFO entries; power of two, >=2
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        asynchronous active-low reset
//  alu_valid   in   1        ALU result valid this cycle; no backpressure, always accepted
//  alu_rd      in   AW       ALU destination register
//  alu_data    in   DW       ALU result
//  mem_valid   in   1        slow result offered
//  mem_rd      in   AW       slow result destination
//  mem_data    in   DW       slow result data
//  mem_ready   out  1        FIFO can accept; transfer = mem_valid & mem_ready
//  issue_valid in   1        decode issues an instruction this cycle
//  issue_long  in   1        issued instruction has a long-latency result
//  issue_rd    in   AW       destination of the issued instruction
//  busy        out  2**AW    busy[i]=1: write to ri outstanding on slow path
//  WE3         out  1        register file write enable (registered)
//  A3          out  AW       register file write address (registered)
//  WD3         out  DW       register file write data (registered)
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, busy=0, WE3=0, A3=0, WD3=0, mem_ready=0.
//   On rst release, mem_ready=1 combinationally from the empty FIFO.
//  mem_ready = rst & !full. No write-through when full: a simultaneous pop does not free a slot in the same cycle.
//  Port arbitration per cycle (registered into WE3/A3/WD3 at the next edge; latency 1):
//   1. alu_valid & alu_rd!=0 -> ALU wins: WE3<=1, A3<=alu_rd, WD3<=alu_data.
//   2. else if FIFO non-empty -> pop head: WE3<=1, A3<=head.rd, WD3<=head.data.
//   3. else -> WE3<=0; A3/WD3 hold their previous values.
//  ALU writes to r0 are dropped and do not consume the slot, so the FIFO may drain.
//  Slow results to r0 are accepted (handshake completes) and discarded; never pushed.
//  FIFO: push on mem_valid&mem_ready&mem_rd!=0; pop per rule 2. Simultaneous push+pop
//   leaves count unchanged. Pointers wrap modulo DEPTH. Count is $clog2(DEPTH+1) bits.
//  Scoreboard, per register i!=0, evaluated at the clock edge:
//   set   = issue_valid & issue_long & issue_rd==i
//   clear = FIFO pop this cycle with head.rd==i
//   set & clear same cycle -> set wins (newer instruction owns the register).
//   busy[0] is constant 0. An ALU write to a busy register does not clear busy.
//  Ordering: slow results leave the FIFO in arrival order. ALU results may overtake
//   queued slow results; decode guarantees no WAW on busy registers via the stall.
//  Starvation: an ALU stream of every-cycle valid writes may starve the FIFO indefinitely.
//   This is accepted, because decode stalls on busy, which throttles the ALU stream.
//  Reset mid-operation: all queued results and busy bits are lost; WE3 drops to 0 asynchronously.
// STRUCTURE
//  Shared package cpu_pkg: DW, AW, NREG=2**AW, typedef wb_entry_t {rd[AW], data[DW]}.
//  Sub-module wb_fifo (DEPTH x wb_entry_t, push/pop/full/empty, async active-low reset).
//  Top level contains the arbiter mux, output registers and the scoreboard. No other state.
// TESTING
//  T1 reset: hold rst=0 while driving traffic -> WE3=0, busy=0, mem_ready=0; release -> mem_ready=1.
//  T2 ALU only: alu r3=16'hBEEF at cycle n -> WE3=1, A3=3, WD3=BEEF at n+1; alu r0 -> WE3=0.
//  T3 contention: issue_long r5, then mem r5=16'h1234 and alu r2=16'h0042 together ->
//   cycle+1 writes r2; cycle+2 writes r5=1234; busy[5] 1->0 on the pop edge.
//  T4 full: ALU valid every cycle, push 2 slow results -> mem_ready=0; a 3rd mem_valid
//   is not accepted; drop alu_valid -> results drain in order, one per cycle, mem_ready=1.
//  T5 set/clear same cycle: r4 head pops while issue_long r4 -> busy[4] stays 1.
//  T6 async reset mid-drain: pull rst low between edges with FIFO=2 -> WE3=0 immediately;
//   after release no stale writes appear.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry and the write-back entry
// carried by the slow-result path.
package cpu_pkg;

    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int NREG = 2 ** AW;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending long-latency write-back entries.
// Callers see a combinational head, plus full and empty flags.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t       mem_q [DEPTH];
    wb_entry_t       mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Guard against misuse so the count can never wrap.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset; the count and pointers decide what is valid, so its contents after reset do not matter.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples values from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Owns the register-file write port. ALU results take priority; queued slow
// results fill the free slots. Also tracks outstanding long-latency destinations.
module writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [AW-1:0]    alu_rd,
    input  logic [DW-1:0]    alu_data,
    input  logic             mem_valid,
    input  logic [AW-1:0]    mem_rd,
    input  logic [DW-1:0]    mem_data,
    output logic             mem_ready,
    input  logic             issue_valid,
    input  logic             issue_long,
    input  logic [AW-1:0]    issue_rd,
    output logic [NREG-1:0]  busy,
    output logic             WE3,
    output logic [AW-1:0]    A3,
    output logic [DW-1:0]    WD3
);

    wb_entry_t        head;
    wb_entry_t        push_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic             alu_win;
    logic             push;
    logic             pop;

    logic             we3_q, we3_d;
    logic [AW-1:0]    a3_q, a3_d;
    logic [DW-1:0]    wd3_q, wd3_d;
    logic [NREG-1:0]  busy_q, busy_d;

    assign push_entry = '{rd: mem_rd, data: mem_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        // A pop in the same cycle does not free a slot for the offered result.
        mem_ready = rst && !fifo_full;
        // Writes to r0 are dropped and leave the slot free for the FIFO.
        alu_win   = alu_valid && (alu_rd != '0);
        pop       = !alu_win && !fifo_empty;
        push      = mem_valid && mem_ready && (mem_rd != '0);

        we3_d = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (alu_win) begin
            we3_d = 1'b1;
            a3_d  = alu_rd;
            wd3_d = alu_data;
        end else if (pop) begin
            we3_d = 1'b1;
            a3_d  = head.rd;
            wd3_d = head.data;
        end

        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if (pop && (head.rd == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
            // A newly issued long instruction owns the register, so set wins over clear.
            if (issue_valid && issue_long && (issue_rd == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we3_q  <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            busy_q <= '0;
        end else begin
            we3_q  <= we3_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            busy_q <= busy_d;
        end
    end

    assign WE3  = we3_q;
    assign A3   = a3_q;
    assign WD3  = wd3_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based
// reference model of the write port, slow FIFO and busy scoreboard.
module tb_writeback_arbiter;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    logic             clk;
    logic             rst;
    logic             alu_valid;
    logic [AW-1:0]    alu_rd;
    logic [DW-1:0]    alu_data;
    logic             mem_valid;
    logic [AW-1:0]    mem_rd;
    logic [DW-1:0]    mem_data;
    logic             mem_ready;
    logic             issue_valid;
    logic             issue_long;
    logic [AW-1:0]    issue_rd;
    logic [NREG-1:0]  busy;
    logic             WE3;
    logic [AW-1:0]    A3;
    logic [DW-1:0]    WD3;

    writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .WE3         (WE3),
        .A3          (A3),
        .WD3         (WD3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    wb_entry_t        mq[$];
    bit [NREG-1:0]    m_busy;
    logic             m_we;
    logic [AW-1:0]    m_a3;
    logic [DW-1:0]    m_wd3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = '0;
        m_we   = 1'b0;
        m_a3   = '0;
        m_wd3  = '0;
    endtask

    // Applies the current inputs to the model as one clock edge.
    task automatic model_edge();
        bit        room;
        wb_entry_t e;
        if (!rst) begin
            model_reset();
            return;
        end
        room = (mq.size() < DEPTH);
        if (alu_valid && alu_rd != 0) begin
            m_we  = 1'b1;
            m_a3  = alu_rd;
            m_wd3 = alu_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we  = 1'b1;
            m_a3  = e.rd;
            m_wd3 = e.data;
            m_busy[e.rd] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (mem_valid && room && mem_rd != 0)
            mq.push_back('{rd: mem_rd, data: mem_data});
        if (issue_valid && issue_long && issue_rd != 0)
            m_busy[issue_rd] = 1'b1;
    endtask

    task automatic set_idle();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
        issue_valid = 0; issue_long = 0; issue_rd = '0;
    endtask

    task automatic randomize_inputs(input int alu_pct);
        alu_valid   = ($urandom_range(0, 99) < alu_pct);
        alu_rd      = AW'($urandom_range(0, NREG - 1));
        alu_data    = DW'($urandom);
        mem_valid   = ($urandom_range(0, 99) < 50);
        mem_rd      = AW'($urandom_range(0, NREG - 1));
        mem_data    = DW'($urandom);
        issue_valid = ($urandom_range(0, 99) < 40);
        issue_long  = ($urandom_range(0, 99) < 50);
        issue_rd    = AW'($urandom_range(0, NREG - 1));
    endtask

    // Inputs are already driven; check mem_ready, clock once, check registered outputs.
    task automatic step(input string tag);
        #1;
        check({tag, ".mem_ready"}, 32'(mem_ready), 32'(rst && (mq.size() < DEPTH)));
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".we3"},  32'(WE3),  32'(m_we));
        check({tag, ".a3"},   32'(A3),   32'(m_a3));
        check({tag, ".wd3"},  32'(WD3),  32'(m_wd3));
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    endtask

    initial begin
        int alu_pct;
        rst = 1'b0;
        set_idle();
        model_reset();

        // T1: traffic under reset has no effect.
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(50);
            issue_valid = 1; issue_long = 1; issue_rd = 3'd5;
            step("t1");
        end
        check("t1.we3_rst", 32'(WE3), 32'd0);
        check("t1.busy_rst", 32'(busy), 32'd0);
        check("t1.ready_rst", 32'(mem_ready), 32'd0);
        set_idle();
        rst = 1'b1;
        #1;
        check("t1.ready_release", 32'(mem_ready), 32'd1);

        // T2: plain ALU write, then an r0 write that must be dropped.
        alu_valid = 1; alu_rd = 3'd3; alu_data = 16'hBEEF;
        step("t2a");
        check("t2.we3", 32'(WE3), 32'd1);
        check("t2.a3",  32'(A3),  32'd3);
        check("t2.wd3", 32'(WD3), 32'hBEEF);
        alu_rd = 3'd0; alu_data = 16'h1111;
        step("t2b");
        check("t2.we3_r0", 32'(WE3), 32'd0);
        check("t2.wd3_hold", 32'(WD3), 32'hBEEF);
        set_idle();

        // T3: ALU and slow result arrive together; ALU first, slow next.
        issue_valid = 1; issue_long = 1; issue_rd = 3'd5;
        step("t3a");
        check("t3.busy5_set", 32'(busy[5]), 32'd1);
        set_idle();
        mem_valid = 1; mem_rd = 3'd5; mem_data = 16'h1234;
        alu_valid = 1; alu_rd = 3'd2; alu_data = 16'h0042;
        step("t3b");
        check("t3.a3_alu", 32'(A3), 32'd2);
        check("t3.busy5_held", 32'(busy[5]), 32'd1);
        set_idle();
        step("t3c");
        check("t3.a3_slow", 32'(A3), 32'd5);
        check("t3.wd3_slow", 32'(WD3), 32'h1234);
        check("t3.busy5_clr", 32'(busy[5]), 32'd0);

        // T4: fill FIFO behind a continuous ALU stream, then drain in order.
        alu_valid = 1; alu_rd = 3'd1; alu_data = 16'h0001;
        mem_valid = 1; mem_rd = 3'd6; mem_data = 16'hA006;
        step("t4a");
        mem_rd = 3'd7; mem_data = 16'hA007;
        step("t4b");
        check("t4.ready_full", 32'(mem_ready), 32'd0);
        mem_rd = 3'd1; mem_data = 16'hDEAD;
        step("t4c");
        set_idle();
        step("t4d");
        check("t4.first_a3", 32'(A3), 32'd6);
        check("t4.first_wd3", 32'(WD3), 32'hA006);
        check("t4.ready_after_pop", 32'(mem_ready), 32'd1);
        step("t4e");
        check("t4.second_wd3", 32'(WD3), 32'hA007);
        step("t4f");
        check("t4.no_third", 32'(WE3), 32'd0);

        // T5: head for r4 pops in the same cycle r4 is reissued long.
        issue_valid = 1; issue_long = 1; issue_rd = 3'd4;
        step("t5a");
        set_idle();
        mem_valid = 1; mem_rd = 3'd4; mem_data = 16'h4444;
        step("t5b");
        set_idle();
        issue_valid = 1; issue_long = 1; issue_rd = 3'd4;
        step("t5c");
        check("t5.a3_pop", 32'(A3), 32'd4);
        check("t5.busy4_kept", 32'(busy[4]), 32'd1);
        set_idle();

        // T6: asynchronous reset with two queued results and a write in flight.
        alu_valid = 1; alu_rd = 3'd2; alu_data = 16'h2222;
        mem_valid = 1; mem_rd = 3'd3; mem_data = 16'h3333;
        issue_valid = 1; issue_long = 1; issue_rd = 3'd3;
        step("t6a");
        mem_rd = 3'd6; mem_data = 16'h6666;
        issue_valid = 0;
        step("t6b");
        check("t6.we3_before", 32'(WE3), 32'd1);
        set_idle();
        #2;
        rst = 1'b0;
        #1;
        check("t6.we3_async", 32'(WE3), 32'd0);
        check("t6.busy_async", 32'(busy), 32'd0);
        check("t6.ready_async", 32'(mem_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("t6c");
            check("t6.no_stale", 32'(WE3), 32'd0);
        end

        // Randomized traffic with varying ALU pressure and rare resets.
        for (int c = 0; c < 900; c++) begin
            case ((c / 100) % 3)
                0:       alu_pct = 90;
                1:       alu_pct = 50;
                default: alu_pct = 10;
            endcase
            randomize_inputs(alu_pct);
            rst = ($urandom_range(0, 149) != 0);
            step("rand");
        end
        rst = 1'b1;
        set_idle();
        for (int i = 0; i < 4; i++) step("flush");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
